// File: rtl/sc_regbank_write.sv
// Write side of a 16-entry register bank that takes its address from either the rd field or the MIR C field.
// Optional macro SC_REGBANK_R0_HARDWIRED_EN makes register 0 read as a constant zero.
module sc_regbank_write #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int DATAWIDTH_MIR_SELECTION        = 6,
  parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5
) (
  input  logic                                      SC_REGBANK_CLOCK_50,
  input  logic                                      SC_REGBANK_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data_InBus,
  input  logic                                      SC_REGBANK_WriteRequest_In,
  input  logic                                      SC_REGBANK_Select_In,
  input  logic [DATAWIDTH_MIR_SELECTION-1:0]        SC_REGBANK_MIRSelection_InBus,
  input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] SC_REGBANK_ScratchpadSelection_InBus,
  input  logic                                      SC_REGBANK_ErrorClear_In,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data0_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data1_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data2_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data3_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data4_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data5_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data6_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data7_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data8_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data9_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data10_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data11_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data12_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data13_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data14_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data15_OutBus,
  output logic                                      SC_REGBANK_WriteAck_Out,
  output logic [5:0]                                SC_REGBANK_LastAddress_OutBus,
  output logic                                      SC_REGBANK_AddressError_Out,
  output logic [7:0]                                SC_REGBANK_WriteCount_OutBus
);

  localparam int NUM_REGS = 16;

  logic [DATAWIDTH_BUS-1:0] regs [NUM_REGS];
  logic [5:0]               eff_addr;
  logic [3:0]               wr_index;
  logic                     in_range;
  logic                     accept;
  logic                     bad_request;

  // Range check uses the full source field so wider address parameters never alias into 0..15.
  always_comb begin
    eff_addr    = 6'd0;
    in_range    = 1'b0;
    if (SC_REGBANK_Select_In) begin
      eff_addr = 6'(SC_REGBANK_MIRSelection_InBus);
      in_range = ((SC_REGBANK_MIRSelection_InBus >> 4) == '0);
    end else begin
      eff_addr = 6'(SC_REGBANK_ScratchpadSelection_InBus);
      in_range = ((SC_REGBANK_ScratchpadSelection_InBus >> 4) == '0);
    end
    wr_index    = eff_addr[3:0];
    accept      = SC_REGBANK_WriteRequest_In && in_range;
    bad_request = SC_REGBANK_WriteRequest_In && !in_range;
  end

  always_ff @(posedge SC_REGBANK_CLOCK_50 or negedge SC_REGBANK_RESET_InLow) begin
    if (!SC_REGBANK_RESET_InLow) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (accept) begin
`ifdef SC_REGBANK_R0_HARDWIRED_EN
      if (wr_index != 4'd0) regs[wr_index] <= SC_REGBANK_data_InBus;
`else
      regs[wr_index] <= SC_REGBANK_data_InBus;
`endif
    end
  end

  // A new error wins over a simultaneous clear so no bad request goes unreported.
  always_ff @(posedge SC_REGBANK_CLOCK_50 or negedge SC_REGBANK_RESET_InLow) begin
    if (!SC_REGBANK_RESET_InLow) begin
      SC_REGBANK_WriteAck_Out       <= 1'b0;
      SC_REGBANK_LastAddress_OutBus <= 6'd0;
      SC_REGBANK_WriteCount_OutBus  <= 8'd0;
      SC_REGBANK_AddressError_Out   <= 1'b0;
    end else begin
      SC_REGBANK_WriteAck_Out <= accept;
      if (accept) begin
        SC_REGBANK_LastAddress_OutBus <= eff_addr;
        SC_REGBANK_WriteCount_OutBus  <= SC_REGBANK_WriteCount_OutBus + 8'd1;
      end
      if (bad_request)
        SC_REGBANK_AddressError_Out <= 1'b1;
      else if (SC_REGBANK_ErrorClear_In)
        SC_REGBANK_AddressError_Out <= 1'b0;
    end
  end

`ifdef SC_REGBANK_R0_HARDWIRED_EN
  assign SC_REGBANK_data0_OutBus  = '0;
`else
  assign SC_REGBANK_data0_OutBus  = regs[0];
`endif
  assign SC_REGBANK_data1_OutBus  = regs[1];
  assign SC_REGBANK_data2_OutBus  = regs[2];
  assign SC_REGBANK_data3_OutBus  = regs[3];
  assign SC_REGBANK_data4_OutBus  = regs[4];
  assign SC_REGBANK_data5_OutBus  = regs[5];
  assign SC_REGBANK_data6_OutBus  = regs[6];
  assign SC_REGBANK_data7_OutBus  = regs[7];
  assign SC_REGBANK_data8_OutBus  = regs[8];
  assign SC_REGBANK_data9_OutBus  = regs[9];
  assign SC_REGBANK_data10_OutBus = regs[10];
  assign SC_REGBANK_data11_OutBus = regs[11];
  assign SC_REGBANK_data12_OutBus = regs[12];
  assign SC_REGBANK_data13_OutBus = regs[13];
  assign SC_REGBANK_data14_OutBus = regs[14];
  assign SC_REGBANK_data15_OutBus = regs[15];

endmodule

// File: tb/tb_sc_regbank_write.sv
// Directed bench for sc_regbank_write: vector table plus back-to-back, wrap and async-reset sequences.
// Define SC_REGBANK_R0_HARDWIRED_EN for both files to check the hardwired register-0 build.
module tb_sc_regbank_write;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        req;
  logic        sel;
  logic [5:0]  mir;
  logic [4:0]  rd;
  logic        clr;
  logic [31:0] dout [16];
  logic        ack;
  logic [5:0]  last;
  logic        err;
  logic [7:0]  cnt;

  int vectors;
  int miscompares;

  sc_regbank_write dut (
    .SC_REGBANK_CLOCK_50                  (clk),
    .SC_REGBANK_RESET_InLow               (rst_n),
    .SC_REGBANK_data_InBus                (data_in),
    .SC_REGBANK_WriteRequest_In           (req),
    .SC_REGBANK_Select_In                 (sel),
    .SC_REGBANK_MIRSelection_InBus        (mir),
    .SC_REGBANK_ScratchpadSelection_InBus (rd),
    .SC_REGBANK_ErrorClear_In             (clr),
    .SC_REGBANK_data0_OutBus              (dout[0]),
    .SC_REGBANK_data1_OutBus              (dout[1]),
    .SC_REGBANK_data2_OutBus              (dout[2]),
    .SC_REGBANK_data3_OutBus              (dout[3]),
    .SC_REGBANK_data4_OutBus              (dout[4]),
    .SC_REGBANK_data5_OutBus              (dout[5]),
    .SC_REGBANK_data6_OutBus              (dout[6]),
    .SC_REGBANK_data7_OutBus              (dout[7]),
    .SC_REGBANK_data8_OutBus              (dout[8]),
    .SC_REGBANK_data9_OutBus              (dout[9]),
    .SC_REGBANK_data10_OutBus             (dout[10]),
    .SC_REGBANK_data11_OutBus             (dout[11]),
    .SC_REGBANK_data12_OutBus             (dout[12]),
    .SC_REGBANK_data13_OutBus             (dout[13]),
    .SC_REGBANK_data14_OutBus             (dout[14]),
    .SC_REGBANK_data15_OutBus             (dout[15]),
    .SC_REGBANK_WriteAck_Out              (ack),
    .SC_REGBANK_LastAddress_OutBus        (last),
    .SC_REGBANK_AddressError_Out          (err),
    .SC_REGBANK_WriteCount_OutBus         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        sel;
    logic [5:0]  mir;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        clr;
    int          chk_idx;
    logic        exp_ack;
    logic [5:0]  exp_last;
    logic [7:0]  exp_cnt;
    logic        exp_err;
    logic [31:0] exp_val;
  } vec_t;

  vec_t tbl [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and return 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [5:0] m, input logic [4:0] d5,
                               input logic [31:0] dat, input logic c);
    req = r; sel = s; mir = m; rd = d5; data_in = dat; clr = c;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r0_after_ffff;
  logic [7:0]  exp_cnt;
  logic [31:0] exp_regs [16];

  initial begin
    vectors = 0;
    miscompares = 0;
`ifdef SC_REGBANK_R0_HARDWIRED_EN
    r0_after_ffff = 32'h0;
`else
    r0_after_ffff = 32'hFFFF_FFFF;
`endif
    //          req  sel  mir    rd     data          clr idx ack last  cnt err val
    tbl[0]  = '{1'b1,1'b1,6'd5, 5'd0, 32'hDEADBEEF,1'b0, 5, 1'b1,6'd5, 8'd1,1'b0,32'hDEADBEEF};
    tbl[1]  = '{1'b1,1'b0,6'd0, 5'd15,32'h12345678,1'b0,15, 1'b1,6'd15,8'd2,1'b0,32'h12345678};
    tbl[2]  = '{1'b0,1'b1,6'd40,5'd0, 32'h0,       1'b0,15, 1'b0,6'd15,8'd2,1'b0,32'h12345678};
    tbl[3]  = '{1'b1,1'b1,6'd40,5'd0, 32'h0000AAAA,1'b0, 5, 1'b0,6'd15,8'd2,1'b1,32'hDEADBEEF};
    tbl[4]  = '{1'b0,1'b0,6'd0, 5'd0, 32'h0,       1'b0, 0, 1'b0,6'd15,8'd2,1'b1,32'h0};
    tbl[5]  = '{1'b1,1'b1,6'd63,5'd0, 32'h55555555,1'b1, 0, 1'b0,6'd15,8'd2,1'b1,32'h0};
    tbl[6]  = '{1'b0,1'b0,6'd0, 5'd0, 32'h0,       1'b1, 0, 1'b0,6'd15,8'd2,1'b0,32'h0};
    tbl[7]  = '{1'b1,1'b0,6'd0, 5'd3, 32'h00000033,1'b0, 3, 1'b1,6'd3, 8'd3,1'b0,32'h00000033};
    tbl[8]  = '{1'b1,1'b1,6'd16,5'd3, 32'h00000099,1'b0, 3, 1'b0,6'd3, 8'd3,1'b1,32'h00000033};
    tbl[9]  = '{1'b1,1'b0,6'd0, 5'd31,32'h00000077,1'b0, 0, 1'b0,6'd3, 8'd3,1'b1,32'h0};
    tbl[10] = '{1'b1,1'b1,6'd0, 5'd9, 32'hFFFFFFFF,1'b1, 0, 1'b1,6'd0, 8'd4,1'b0,r0_after_ffff};
    tbl[11] = '{1'b1,1'b0,6'd40,5'd1, 32'h00000011,1'b0, 1, 1'b1,6'd1, 8'd5,1'b0,32'h00000011};

    rst_n = 1'b0;
    req = 1'b0; sel = 1'b0; mir = 6'd0; rd = 5'd0; data_in = 32'h0; clr = 1'b0;
    #12;
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_cnt", 32'(cnt), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_last", 32'(last), 32'd0);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("reset_reg%0d", i), dout[i], 32'd0);
    #10 rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      applyStimulus(tbl[v].req, tbl[v].sel, tbl[v].mir, tbl[v].rd, tbl[v].data, tbl[v].clr);
      checkOutput($sformatf("v%0d_ack", v), 32'(ack), 32'(tbl[v].exp_ack));
      checkOutput($sformatf("v%0d_last", v), 32'(last), 32'(tbl[v].exp_last));
      checkOutput($sformatf("v%0d_cnt", v), 32'(cnt), 32'(tbl[v].exp_cnt));
      checkOutput($sformatf("v%0d_err", v), 32'(err), 32'(tbl[v].exp_err));
      checkOutput($sformatf("v%0d_reg%0d", v, tbl[v].chk_idx), dout[tbl[v].chk_idx], tbl[v].exp_val);
    end

    // Back-to-back writes to every address: ack must stay high every cycle.
    exp_cnt = 8'd5;
    for (int a = 0; a < 16; a++) begin
      exp_regs[a] = 32'hA5000000 | (32'(a) * 32'h00010101);
      applyStimulus(1'b1, 1'b0, 6'd50, 5'(a), exp_regs[a], 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      checkOutput($sformatf("b2b%0d_ack", a), 32'(ack), 32'd1);
      checkOutput($sformatf("b2b%0d_last", a), 32'(last), 32'(a));
      checkOutput($sformatf("b2b%0d_cnt", a), 32'(cnt), 32'(exp_cnt));
    end
`ifdef SC_REGBANK_R0_HARDWIRED_EN
    exp_regs[0] = 32'h0;
`endif
    applyStimulus(1'b0, 1'b1, 6'd7, 5'd7, 32'hBAD0BAD0, 1'b0);
    checkOutput("b2b_idle_ack", 32'(ack), 32'd0);
    for (int a = 0; a < 16; a++) checkOutput($sformatf("b2b_reg%0d", a), dout[a], exp_regs[a]);

    // 256 accepted writes bring the counter back to where it started, passing through 0.
    for (int j = 0; j < 256; j++) begin
      applyStimulus(1'b1, 1'b1, 6'd7, 5'd0, 32'(j), 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      if (exp_cnt == 8'd0) checkOutput("wrap_zero", 32'(cnt), 32'd0);
    end
    checkOutput("wrap_cnt", 32'(cnt), 32'(exp_cnt));
    checkOutput("wrap_reg7", dout[7], 32'd255);

    // Reset asserted between edges while a write is pending.
    req = 1'b1; sel = 1'b1; mir = 6'd9; data_in = 32'hCAFEF00D; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ack", 32'(ack), 32'd0);
    checkOutput("async_cnt", 32'(cnt), 32'd0);
    checkOutput("async_last", 32'(last), 32'd0);
    checkOutput("async_reg7", dout[7], 32'd0);
    checkOutput("async_reg15", dout[15], 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("async_reg9_lost", dout[9], 32'd0);
    checkOutput("async_ack_lost", 32'(ack), 32'd0);
    applyStimulus(1'b1, 1'b0, 6'd0, 5'd2, 32'h0000_2222, 1'b0);
    checkOutput("post_rst_ack", 32'(ack), 32'd1);
    checkOutput("post_rst_cnt", 32'(cnt), 32'd1);
    checkOutput("post_rst_last", 32'(last), 32'd2);
    checkOutput("post_rst_reg2", dout[2], 32'h0000_2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
